// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory controller: address/data types, access flags,
// controller state encodings, the IO address marker and a request-size normaliser.
// No ports; imported by mem_ctrl.
package mem_ctrl_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    localparam logic READ_FLAG  = 1'b0;
    localparam logic WRITE_FLAG = 1'b1;
    localparam logic TRUE       = 1'b1;
    localparam logic FALSE      = 1'b0;

    // mem_a[17:16] value that marks the IO window
    localparam logic [1:0] MC_IO_ADDR_HI = 2'b11;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2
    } mc_state_e;

    typedef struct packed {
        logic       rw;
        logic [2:0] size;
        addr_t      addr;
        data_t      data;
    } lsu_req_t;

    // Anything other than 1 or 2 bytes is served as a full word
    function automatic logic [2:0] norm_size(input logic [2:0] size);
        return (size == 3'd1 || size == 3'd2) ? size : 3'd4;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Purpose: arbitrates LSU data and icache fetch requests onto one byte-wide RAM port, serialising
//   1/2/4-byte little-endian accesses; one finish pulse per request. Read finish N+1 cycles after accept,
//   write finish N+2 cycles plus IO stall cycles. rdy=0 freezes all state; IO writes stall on io_buffer_full.
// Ports: clk/rst/rdy; LSU request (enable/rw/size/address/data) -> finish/data; icache request
//   (enable/address) -> finish/inst; rollback_signal; RAM port mem_din/mem_dout/mem_a/mem_wr; io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [1:0] IO_ADDR_HI = MC_IO_ADDR_HI
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        enable_signal_from_lsu,
    input  logic        rw_flag_from_lsu,
    input  logic [2:0]  size_from_lsu,
    input  logic [31:0] address_from_lsu,
    input  logic [31:0] data_from_lsu,
    output logic        finish_flag_to_lsu,
    output logic [31:0] data_to_lsu,
    input  logic        enable_signal_from_icache,
    input  logic [31:0] address_from_icache,
    output logic        finish_flag_to_icache,
    output logic [31:0] inst_to_icache,
    input  logic        rollback_signal,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    mc_state_e  state_q;
    logic       owner_lsu_q;
    logic [2:0] idx_q;
    logic [2:0] size_q;
    addr_t      addr_q;
    data_t      wdata_q;
    data_t      shift_q;
    logic       pending_q;
    lsu_req_t   slot_q;
    logic       finish_lsu_q;
    logic       finish_ic_q;
    data_t      data_lsu_q;
    data_t      inst_q;
    addr_t      mem_a_q;
    logic [7:0] mem_dout_q;
    logic       mem_wr_q;

    lsu_req_t   lsu_new;
    lsu_req_t   lsu_sel;
    logic       lsu_req;
    logic       lsu_accept;
    logic       last_byte;
    logic       io_stall;
    data_t      shift_nxt;
    data_t      read_word;
    logic [7:0] wr_byte;

    always_comb begin
        lsu_new    = '{rw: rw_flag_from_lsu, size: norm_size(size_from_lsu),
                       addr: address_from_lsu, data: data_from_lsu};
        // A latched request and a fresh pulse never coexist, so the slot simply wins when full
        lsu_sel    = pending_q ? slot_q : lsu_new;
        lsu_req    = pending_q | enable_signal_from_lsu;
        lsu_accept = (state_q == MC_IDLE) && lsu_req;

        // Bytes enter at the top and walk down; the final word is right-aligned by size,
        // which leaves unused upper bytes at zero.
        shift_nxt  = {mem_din, shift_q[31:8]};
        case (size_q)
            3'd1:    read_word = {24'd0, shift_nxt[31:24]};
            3'd2:    read_word = {16'd0, shift_nxt[31:16]};
            default: read_word = shift_nxt;
        endcase
        last_byte  = (idx_q + 3'd1) == size_q;

        io_stall   = io_buffer_full && (addr_q[17:16] == IO_ADDR_HI);
        wr_byte    = wdata_q[{idx_q[1:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= MC_IDLE;
            owner_lsu_q  <= FALSE;
            idx_q        <= '0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            shift_q      <= '0;
            pending_q    <= FALSE;
            slot_q       <= '0;
            finish_lsu_q <= FALSE;
            finish_ic_q  <= FALSE;
            data_lsu_q   <= '0;
            inst_q       <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            mem_wr_q     <= FALSE;
        end else if (rdy) begin
            finish_lsu_q <= FALSE;
            finish_ic_q  <= FALSE;
            mem_wr_q     <= FALSE;

            // Pulses arriving while busy are parked until the controller is idle again
            if (enable_signal_from_lsu && !lsu_accept) begin
                slot_q    <= lsu_new;
                pending_q <= TRUE;
            end else if (lsu_accept) begin
                pending_q <= FALSE;
            end

            case (state_q)
                MC_IDLE: begin
                    if (lsu_req) begin
                        owner_lsu_q <= TRUE;
                        addr_q      <= lsu_sel.addr;
                        size_q      <= lsu_sel.size;
                        wdata_q     <= lsu_sel.data;
                        idx_q       <= '0;
                        shift_q     <= '0;
                        if (lsu_sel.rw == WRITE_FLAG) begin
                            state_q <= MC_WRITE;
                        end else begin
                            state_q <= MC_READ;
                            mem_a_q <= lsu_sel.addr;
                        end
                    end else if (enable_signal_from_icache && !rollback_signal) begin
                        owner_lsu_q <= FALSE;
                        addr_q      <= address_from_icache;
                        size_q      <= 3'd4;
                        idx_q       <= '0;
                        shift_q     <= '0;
                        mem_a_q     <= address_from_icache;
                        state_q     <= MC_READ;
                    end
                end
                MC_READ: begin
                    if (!owner_lsu_q && rollback_signal) begin
                        // Flushed fetch: drop it silently, LSU work is never aborted
                        state_q <= MC_IDLE;
                    end else begin
                        shift_q <= shift_nxt;
                        if (last_byte) begin
                            state_q <= MC_IDLE;
                            if (owner_lsu_q) begin
                                finish_lsu_q <= TRUE;
                                data_lsu_q   <= read_word;
                            end else begin
                                finish_ic_q  <= TRUE;
                                inst_q       <= read_word;
                            end
                        end else begin
                            mem_a_q <= addr_q + 32'(idx_q) + 32'd1;
                            idx_q   <= idx_q + 3'd1;
                        end
                    end
                end
                MC_WRITE: begin
                    if (idx_q == size_q) begin
                        finish_lsu_q <= TRUE;
                        state_q      <= MC_IDLE;
                    end else if (!io_stall) begin
                        mem_wr_q   <= TRUE;
                        mem_a_q    <= addr_q + 32'(idx_q);
                        mem_dout_q <= wr_byte;
                        idx_q      <= idx_q + 3'd1;
                    end
                end
                default: state_q <= MC_IDLE;
            endcase
        end
    end

    assign finish_flag_to_lsu    = finish_lsu_q;
    assign data_to_lsu           = data_lsu_q;
    assign finish_flag_to_icache = finish_ic_q;
    assign inst_to_icache        = inst_q;
    assign mem_a                 = mem_a_q;
    assign mem_dout              = mem_dout_q;
    assign mem_wr                = mem_wr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        lsu_en, lsu_rw;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_data;
    logic        fin_lsu;
    logic [31:0] data_to_lsu;
    logic        ic_en;
    logic [31:0] ic_addr;
    logic        fin_ic;
    logic [31:0] inst;
    logic        rollback;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t wlog[$];

    logic [7:0] ram [0:262143];

    mem_ctrl dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .enable_signal_from_lsu    (lsu_en),
        .rw_flag_from_lsu          (lsu_rw),
        .size_from_lsu             (lsu_size),
        .address_from_lsu          (lsu_addr),
        .data_from_lsu             (lsu_data),
        .finish_flag_to_lsu        (fin_lsu),
        .data_to_lsu               (data_to_lsu),
        .enable_signal_from_icache (ic_en),
        .address_from_icache       (ic_addr),
        .finish_flag_to_icache     (fin_ic),
        .inst_to_icache            (inst),
        .rollback_signal           (rollback),
        .mem_din                   (mem_din),
        .mem_dout                  (mem_dout),
        .mem_a                     (mem_a),
        .mem_wr                    (mem_wr),
        .io_buffer_full            (io_full)
    );

    always #5 clk = ~clk;

    // RAM model: preloaded during reset, written when mem_wr is seen at a rising edge,
    // read byte follows the address presented in the current cycle.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
            ram[18'h00100] <= 8'h78;
            ram[18'h00101] <= 8'h56;
            ram[18'h00102] <= 8'h34;
            ram[18'h00103] <= 8'h12;
            ram[18'h00010] <= 8'hA5;
            ram[18'h00000] <= 8'h13;
            ram[18'h00020] <= 8'h93;
            ram[18'h00021] <= 8'h80;
            ram[18'h00022] <= 8'h10;
            ram[18'h3FFFF] <= 8'hC3;
        end else if (mem_wr) begin
            ram[mem_a[17:0]] <= mem_dout;
            wlog.push_back('{a: mem_a, d: mem_dout});
        end
    end

    always @(negedge clk) mem_din <= ram[mem_a[17:0]];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_lsu(input logic rw, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        lsu_en   = 1'b1;
        lsu_rw   = rw;
        lsu_size = sz;
        lsu_addr = a;
        lsu_data = d;
    endtask

    // Counts negedges after the pulse cycle until finish_flag_to_lsu; -1 on timeout
    task automatic wait_lsu(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 1) lsu_en = 1'b0;
            if (fin_lsu) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_ic(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (fin_ic) begin
                lat = c;
                ic_en = 1'b0;
                break;
            end
        end
    endtask

    typedef struct {
        logic        rw;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        io_full;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat;
        int cyc;
        int seen;

        vecs[0]  = '{1'b0, 3'd4, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678, 5};
        vecs[1]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,         1'b0, 32'h0000_1234, 3};
        vecs[2]  = '{1'b0, 3'd1, 32'h0000_0103, 32'h0,         1'b0, 32'h0000_0012, 2};
        vecs[3]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678, 5};
        vecs[4]  = '{1'b1, 3'd4, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 32'h0,         6};
        vecs[5]  = '{1'b0, 3'd4, 32'h0000_0400, 32'h0,         1'b0, 32'hCAFE_F00D, 5};
        vecs[6]  = '{1'b1, 3'd1, 32'h0000_0500, 32'hFFFF_FF99, 1'b0, 32'h0,         3};
        vecs[7]  = '{1'b0, 3'd2, 32'h0000_04FF, 32'h0,         1'b0, 32'h0000_9900, 3};
        vecs[8]  = '{1'b0, 3'd4, 32'hFFFF_FFFF, 32'h0,         1'b0, 32'h0000_13C3, 5};
        vecs[9]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000_7766, 1'b0, 32'h0,         4};
        vecs[10] = '{1'b0, 3'd0, 32'h0000_0100, 32'h0,         1'b0, 32'h1234_5678, 5};

        rst = 1'b1; rdy = 1'b1; lsu_en = 1'b0; lsu_rw = 1'b0; lsu_size = 3'd0;
        lsu_addr = '0; lsu_data = '0; ic_en = 1'b0; ic_addr = '0; rollback = 1'b0; io_full = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_fin_lsu", 32'(fin_lsu), 32'd0);
        chk("rst_fin_ic", 32'(fin_ic), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_data_lsu", data_to_lsu, 32'd0);
        chk("rst_inst", inst, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch in progress, SH pulses mid-fetch: fetch finishes first, then the store
        tick(); wlog.delete(); ic_en = 1'b1; ic_addr = 32'h0;
        tick();
        tick(); pulse_lsu(1'b1, 3'd2, 32'h0000_0200, 32'h0000_BEEF);
        tick(); lsu_en = 1'b0;
        tick(); chk("t3_fin_ic_early", 32'(fin_ic), 32'd0);
        tick(); chk("t3_fin_ic", 32'(fin_ic), 32'd1);
                chk("t3_inst", inst, 32'h0000_0013);
                chk("t3_fin_lsu_early", 32'(fin_lsu), 32'd0);
                ic_en = 1'b0;
        tick(); chk("t3_fin_ic_width", 32'(fin_ic), 32'd0);
                chk("t3_accept_wr0", 32'(mem_wr), 32'd0);
        tick(); chk("t3_wr0", 32'(mem_wr), 32'd1);
                chk("t3_a0", mem_a, 32'h0000_0200);
                chk("t3_d0", 32'(mem_dout), 32'h0000_00EF);
        tick(); chk("t3_wr1", 32'(mem_wr), 32'd1);
                chk("t3_a1", mem_a, 32'h0000_0201);
                chk("t3_d1", 32'(mem_dout), 32'h0000_00BE);
        tick(); chk("t3_fin_lsu", 32'(fin_lsu), 32'd1);
                chk("t3_wr_idle", 32'(mem_wr), 32'd0);
                chk("t3_wcount", 32'(wlog.size()), 32'd2);

        // Fetch and LBU in the same idle cycle: LSU first, fetch next
        tick(); ic_en = 1'b1; ic_addr = 32'h20; pulse_lsu(1'b0, 3'd1, 32'h10, 32'h0);
        tick(); lsu_en = 1'b0;
                chk("t4_mem_a_lsu", mem_a, 32'h0000_0010);
        tick(); chk("t4_fin_lsu", 32'(fin_lsu), 32'd1);
                chk("t4_data", data_to_lsu, 32'h0000_00A5);
                chk("t4_fin_ic_early", 32'(fin_ic), 32'd0);
        wait_ic(lat);
        chk("t4_ic_lat", 32'(lat), 32'd5);
        chk("t4_inst", inst, 32'h0010_8093);

        // Rollback two cycles into a fetch: aborted, idle on the next cycle
        tick(); ic_en = 1'b1; ic_addr = 32'h0;
        tick();
        tick(); rollback = 1'b1; ic_en = 1'b0;
        tick(); rollback = 1'b0; pulse_lsu(1'b0, 3'd1, 32'h10, 32'h0);
                chk("t5_fin_ic_a", 32'(fin_ic), 32'd0);
                chk("t5_mem_wr", 32'(mem_wr), 32'd0);
        tick(); lsu_en = 1'b0;
                chk("t5_fin_ic_b", 32'(fin_ic), 32'd0);
        tick(); chk("t5_fin_ic_c", 32'(fin_ic), 32'd0);
                chk("t5_lbu_fin", 32'(fin_lsu), 32'd1);
                chk("t5_lbu_data", data_to_lsu, 32'h0000_00A5);
        tick(); ic_en = 1'b1; ic_addr = 32'h20;
        wait_ic(lat);
        chk("t5_refetch_lat", 32'(lat), 32'd5);
        chk("t5_refetch_inst", inst, 32'h0010_8093);

        // Rollback in idle masks a same-cycle fetch
        tick(); ic_en = 1'b1; ic_addr = 32'h20; rollback = 1'b1;
        tick(); ic_en = 1'b0; rollback = 1'b0;
        seen = 0;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (fin_ic) seen++;
        end
        chk("idle_rollback_no_fetch", 32'(seen), 32'd0);

        // IO store stalled by io_buffer_full
        tick(); wlog.delete(); io_full = 1'b1; pulse_lsu(1'b1, 3'd1, 32'h0003_0000, 32'h41);
        tick(); lsu_en = 1'b0; chk("t2_stall_a", 32'(mem_wr), 32'd0);
        tick(); chk("t2_stall_b", 32'(mem_wr), 32'd0);
        tick(); chk("t2_stall_c", 32'(mem_wr), 32'd0);
                io_full = 1'b0;
        tick(); chk("t2_wr", 32'(mem_wr), 32'd1);
                chk("t2_a", mem_a, 32'h0003_0000);
                chk("t2_d", 32'(mem_dout), 32'h0000_0041);
                chk("t2_fin_early", 32'(fin_lsu), 32'd0);
        tick(); chk("t2_fin", 32'(fin_lsu), 32'd1);
                chk("t2_wr_idle", 32'(mem_wr), 32'd0);
                chk("t2_wcount", 32'(wlog.size()), 32'd1);

        // rdy low for 4 cycles in the middle of a load
        tick(); pulse_lsu(1'b0, 3'd4, 32'h100, 32'h0);
        tick(); lsu_en = 1'b0;
        tick(); chk("t6_mem_a_run", mem_a, 32'h0000_0101);
                rdy = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            tick();
            chk($sformatf("t6_mem_a_frozen_%0d", c), mem_a, 32'h0000_0101);
            chk($sformatf("t6_fin_frozen_%0d", c), 32'(fin_lsu), 32'd0);
        end
        rdy = 1'b1;
        cyc = 6;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            cyc++;
            if (fin_lsu) begin
                lat = cyc;
                break;
            end
        end
        chk("t6_lat", 32'(lat), 32'd9);
        chk("t6_data", data_to_lsu, 32'h1234_5678);

        // Table-driven LSU accesses
        for (int i = 0; i < 11; i++) begin
            tick();
            wlog.delete();
            io_full = vecs[i].io_full;
            pulse_lsu(vecs[i].rw, vecs[i].size, vecs[i].addr, vecs[i].wdata);
            wait_lsu(lat);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].rw == 1'b0)
                chk($sformatf("v%0d_rdata", i), data_to_lsu, vecs[i].exp_rdata);
            tick();
            chk($sformatf("v%0d_fin_width", i), 32'(fin_lsu), 32'd0);
            io_full = 1'b0;
            if (vecs[i].rw == 1'b1) begin
                chk($sformatf("v%0d_wcount", i), 32'(wlog.size()), 32'(vecs[i].size));
                for (int k = 0; k < int'(vecs[i].size) && k < wlog.size(); k++) begin
                    chk($sformatf("v%0d_waddr%0d", i, k), wlog[k].a, vecs[i].addr + 32'(k));
                    chk($sformatf("v%0d_wbyte%0d", i, k), 32'(wlog[k].d),
                        32'(8'(vecs[i].wdata >> (8 * k))));
                end
            end else begin
                chk($sformatf("v%0d_no_writes", i), 32'(wlog.size()), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
